// File: rtl/myproject_sdiv_29s_13s_16_seq.sv
// Multi-cycle signed divider: 29b signed dividend / 13b signed divisor ->
// 16b signed quotient (truncated toward zero) and 13b signed remainder.
// Radix-2 restoring division on magnitudes, one quotient bit per enabled cycle.
// Optional SDIV_SATURATE_EN: clamp quotient on overflow / divide-by-zero
// instead of wrapping.
module myproject_sdiv_29s_13s_16_seq #(
  parameter int DIVIDEND_W = 29,
  parameter int DIVISOR_W  = 13,
  parameter int QUOTIENT_W = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  busy,
  output logic                  done,
  output logic [QUOTIENT_W-1:0] dout_quo,
  output logic [DIVISOR_W-1:0]  dout_rem,
  output logic                  ovf,
  output logic                  dz
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam int QW_W  = DIVIDEND_W + 1;  // signed quotient before narrowing

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] quo_acc;   // dividend magnitude shifts out, quotient bits shift in
  logic [DIVISOR_W-1:0]  rem_acc;   // partial remainder, always < divisor magnitude
  logic [DIVISOR_W-1:0]  dvs_mag;
  logic                  sgn_n, sgn_d, zero_d;

  logic [DIVISOR_W:0]    rem_sh, rem_try;
  logic                  step_ok;
  logic [QW_W-1:0]       quo_wide;
  logic [DIVISOR_W-1:0]  rem_sgn;
  logic [QUOTIENT_W-1:0] quo_fix;
  logic [DIVISOR_W-1:0]  rem_fix;
  logic                  ovf_fix;

  // One restoring step: bring down next dividend bit, try subtracting the divisor
  assign rem_sh  = {rem_acc, quo_acc[DIVIDEND_W-1]};
  assign rem_try = rem_sh - {1'b0, dvs_mag};
  assign step_ok = ~rem_try[DIVISOR_W];

  // Apply signs: quotient negative when operand signs differ, remainder follows dividend
  assign quo_wide = (sgn_n ^ sgn_d) ? -{1'b0, quo_acc} : {1'b0, quo_acc};
  assign rem_sgn  = sgn_n ? -rem_acc : rem_acc;

  // Final result selection, including overflow detection and divide-by-zero handling
  always_comb begin
    ovf_fix = ~zero_d & ~((&quo_wide[QW_W-1:QUOTIENT_W-1]) | ~(|quo_wide[QW_W-1:QUOTIENT_W-1]));
    quo_fix = quo_wide[QUOTIENT_W-1:0];
    rem_fix = rem_sgn;
    if (zero_d) begin
      quo_fix = '1;
      rem_fix = '0;
    end
`ifdef SDIV_SATURATE_EN
    if (ovf_fix)
      quo_fix = quo_wide[QW_W-1] ? {1'b1, {(QUOTIENT_W-1){1'b0}}}
                                 : {1'b0, {(QUOTIENT_W-1){1'b1}}};
    if (zero_d)
      quo_fix = sgn_n ? {1'b1, {(QUOTIENT_W-1){1'b0}}}
                      : {1'b0, {(QUOTIENT_W-1){1'b1}}};
`endif
  end

  // Next-state: IDLE -> CALC on start, CALC runs one step per dividend bit, FIX publishes
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  if (cnt == CNT_W'(DIVIDEND_W - 1)) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // State register; ce=0 freezes everything
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)  state <= S_IDLE;
    else if (ce) state <= state_nxt;
  end

  // Datapath: operand capture, iteration, result registers and done pulse
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cnt      <= '0;
      quo_acc  <= '0;
      rem_acc  <= '0;
      dvs_mag  <= '0;
      sgn_n    <= 1'b0;
      sgn_d    <= 1'b0;
      zero_d   <= 1'b0;
      done     <= 1'b0;
      dout_quo <= '0;
      dout_rem <= '0;
      ovf      <= 1'b0;
      dz       <= 1'b0;
    end else if (ce) begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          // magnitudes are unsigned, so the most negative operand is exact
          quo_acc <= din0[DIVIDEND_W-1] ? -din0 : din0;
          dvs_mag <= din1[DIVISOR_W-1]  ? -din1 : din1;
          rem_acc <= '0;
          sgn_n   <= din0[DIVIDEND_W-1];
          sgn_d   <= din1[DIVISOR_W-1];
          zero_d  <= (din1 == '0);
          cnt     <= '0;
        end
        S_CALC: begin
          rem_acc <= step_ok ? rem_try[DIVISOR_W-1:0] : rem_sh[DIVISOR_W-1:0];
          quo_acc <= {quo_acc[DIVIDEND_W-2:0], step_ok};
          cnt     <= cnt + 1'b1;
        end
        S_FIX: begin
          dout_quo <= quo_fix;
          dout_rem <= rem_fix;
          ovf      <= ovf_fix;
          dz       <= zero_d;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_sdiv_29s_13s_16_seq.sv
// Self-checking bench for myproject_sdiv_29s_13s_16_seq: integer-arithmetic
// reference model with an enabled-edge schedule, a per-cycle compare process,
// directed cases with literal expectations, then randomized traffic.
module tb_myproject_sdiv_29s_13s_16_seq;

  logic        clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ce = 1'b0, start = 1'b0;
  logic [28:0] din0 = '0;
  logic [12:0] din1 = '0;
  logic        busy, done, ovf, dz;
  logic [15:0] dout_quo;
  logic [12:0] dout_rem;

  int checks = 0, failures = 0;

  myproject_sdiv_29s_13s_16_seq dut (
    .ap_clk(clk), .ap_rst(ap_rst), .ce(ce), .start(start), .din0(din0), .din1(din1),
    .busy(busy), .done(done), .dout_quo(dout_quo), .dout_rem(dout_rem), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference: plain integer division, truncating toward zero
  function automatic void model(input logic signed [28:0] a, input logic signed [12:0] b,
                                output logic [15:0] q, output logic [12:0] r,
                                output logic o, output logic z);
    longint la, lb, lq, lr;
    la = a; lb = b;
    if (lb == 0) begin
      z = 1'b1; o = 1'b0; r = '0;
`ifdef SDIV_SATURATE_EN
      q = (la >= 0) ? 16'h7FFF : 16'h8000;
`else
      q = 16'hFFFF;
`endif
    end else begin
      lq = la / lb;
      lr = la % lb;
      z = 1'b0;
      o = (lq > 32767) || (lq < -32768);
      r = lr[12:0];
      q = lq[15:0];
`ifdef SDIV_SATURATE_EN
      if (o) q = (lq < 0) ? 16'h8000 : 16'h7FFF;
`endif
    end
  endfunction

  // Model schedule: accepted op completes 30 enabled edges after its start edge
  int          ecnt = 0, due = 0;
  bit          pend = 0, m_done = 0, m_ovf = 0, m_dz = 0, p_ovf, p_dz;
  logic [15:0] m_quo = '0, p_quo;
  logic [12:0] m_rem = '0, p_rem;

  always @(posedge clk or posedge ap_rst) begin
    if (ap_rst) begin
      pend = 0; m_done = 0; m_quo = '0; m_rem = '0; m_ovf = 0; m_dz = 0;
    end else if (ce) begin
      ecnt++;
      if (pend && ecnt == due) begin
        pend = 0; m_done = 1;
        m_quo = p_quo; m_rem = p_rem; m_ovf = p_ovf; m_dz = p_dz;
      end else begin
        m_done = 0;
        if (!pend && start) begin
          pend = 1; due = ecnt + 30;
          model(din0, din1, p_quo, p_rem, p_ovf, p_dz);
        end
      end
    end
  end

  // Compare process: every cycle, all outputs against the model
  always @(negedge clk) begin
    chk("busy", busy, pend);
    chk("done", done, m_done);
    chk("quo", dout_quo, m_quo);
    chk("rem", dout_rem, m_rem);
    chk("ovf", ovf, m_ovf);
    chk("dz", dz, m_dz);
  end

  task automatic issue(input logic [28:0] a, input logic [12:0] b);
    int w = 0;
    @(negedge clk); #1;
    ce = 1'b1; start = 1'b0;
    while (busy && w < 100) begin @(negedge clk); #1; w++; end
    if (busy) chk("idle_timeout", 1, 0);
    din0 = a; din1 = b; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; din0 = 29'($urandom); din1 = 13'($urandom);
  endtask

  // Issue, wait for done (bounded), check latency and literal results
  task automatic run_lit(input string nm, input logic [28:0] a, input logic [12:0] b,
                         input logic [15:0] eq, input logic [12:0] er,
                         input logic eo, input logic ez, input int lat,
                         input int gap_at, input int gap_len, input int rep_at);
    int n = 0; bit got = 0;
    issue(a, b);
    while (!got && n < 200) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) got = 1;
      else begin
        ce = !(n >= gap_at && n < gap_at + gap_len);
        if (n == rep_at) begin start = 1'b1; din0 = 29'd12345; din1 = 13'd11; end
        else start = 1'b0;
      end
    end
    start = 1'b0; ce = 1'b1;
    chk({nm, "_done"}, got, 1);
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_quo"}, dout_quo, eq);
    chk({nm, "_rem"}, dout_rem, er);
    chk({nm, "_ovf"}, ovf, eo);
    chk({nm, "_dz"}, dz, ez);
  endtask

  logic [15:0] tq; logic [12:0] tr; logic to, tz;
  int qa, qb, mode;

  initial begin
    // model pinned against hand-computed values
    model(29'd1000, 13'd7, tq, tr, to, tz);
    chk("m_quo", tq, 16'd142); chk("m_rem", tr, 13'd6);
    model(29'(-1000), 13'd7, tq, tr, to, tz);
    chk("m_quo_neg", tq, 16'hFF72); chk("m_rem_neg", tr, 13'h1FFA);
    model(29'd1000, 13'(-7), tq, tr, to, tz);
    chk("m_rem_pos", tr, 13'd6);

    // reset state
    #2;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_quo", dout_quo, 0);
    chk("rst_rem", dout_rem, 0); chk("rst_ovf", ovf, 0); chk("rst_dz", dz, 0);
    repeat (2) @(negedge clk);
    #1 ap_rst = 1'b0;

    run_lit("t1", 29'd1000, 13'd7, 16'd142, 13'd6, 0, 0, 30, 999, 0, -1);
    run_lit("t2a", 29'(-1000), 13'd7, 16'hFF72, 13'h1FFA, 0, 0, 30, 999, 0, -1);
    run_lit("t2b", 29'd1000, 13'(-7), 16'hFF72, 13'd6, 0, 0, 30, 999, 0, -1);
    run_lit("t2c", 29'(-1000), 13'(-7), 16'd142, 13'h1FFA, 0, 0, 30, 999, 0, -1);
    run_lit("t3a", 29'd95018, 13'(-77), 16'hFB2E, 13'd0, 0, 0, 30, 999, 0, -1);
`ifdef SDIV_SATURATE_EN
    run_lit("t3b", 29'(-268435456), 13'd4096, 16'h8000, 13'd0, 1, 0, 30, 999, 0, -1);
    run_lit("t4a", 29'd1048576, 13'd1, 16'h7FFF, 13'd0, 1, 0, 30, 999, 0, -1);
    run_lit("t4b", 29'(-5), 13'd0, 16'h8000, 13'd0, 0, 1, 30, 999, 0, -1);
`else
    run_lit("t3b", 29'(-268435456), 13'd4096, 16'h0000, 13'd0, 1, 0, 30, 999, 0, -1);
    run_lit("t4a", 29'd1048576, 13'd1, 16'h0000, 13'd0, 1, 0, 30, 999, 0, -1);
    run_lit("t4b", 29'(-5), 13'd0, 16'hFFFF, 13'd0, 0, 1, 30, 999, 0, -1);
`endif
    run_lit("t5a", 29'd1000, 13'd7, 16'd142, 13'd6, 0, 0, 30, 999, 0, 5);
    run_lit("t5b", 29'd1000, 13'd7, 16'd142, 13'd6, 0, 0, 35, 10, 5, -1);
    run_lit("edge", 29'd4095, 13'(-4096), 16'd0, 13'd4095, 0, 0, 30, 999, 0, -1);

    // reset between edges mid-CALC: outputs clear at once, no done follows
    issue(29'd1000, 13'd7);
    repeat (9) @(negedge clk);
    #2 ap_rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0); chk("mid_rst_quo", dout_quo, 0);
    chk("mid_rst_rem", dout_rem, 0); chk("mid_rst_done", done, 0);
    @(negedge clk); #1 ap_rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("mid_rst_no_done", done, 0);
    end
    run_lit("t6", 29'd100, 13'd3, 16'd33, 13'd1, 0, 0, 30, 999, 0, -1);

    // randomized traffic with random ce and start; compare process checks everything
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      ce    = ($urandom % 8) != 0;
      start = ($urandom % 3) == 0;
      mode  = $urandom % 4;
      case (mode)
        0: din0 = 29'($urandom);
        1: din0 = 29'(int'($urandom_range(0, 4000)) - 2000);
        2: begin
             qa = int'($urandom_range(0, 65535)) - 32768;
             qb = int'($urandom_range(0, 8191)) - 4096;
             din0 = 29'(qa * qb);
           end
        default: din0 = ($urandom % 2) ? 29'h10000000 : 29'h0FFFFFFF;
      endcase
      case ($urandom % 4)
        0: din1 = ($urandom % 2) ? 13'd0 : 13'h1000;
        1: din1 = 13'(int'($urandom_range(0, 40)) - 20);
        default: din1 = 13'($urandom);
      endcase
    end
    start = 1'b0; ce = 1'b1;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
